// File: rtl/sys_io_pkg.sv
// ============================================================================
// Module : sys_io_pkg
// Brief  : Shared types and helpers for the PS<->PL serial GPIO mailbox.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package sys_io_pkg;

  typedef enum logic [0:0] {
    CH_IDLE = 1'b0,
    CH_PEND = 1'b1
  } ch_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Low bit of channel ch inside a flat N_CH*word_w bus.
  function automatic int ch_lsb(input int ch, input int word_w);
    return ch * word_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sys_io_if.sv
// ============================================================================
// Module : sys_io_if
// Brief  : PS/PL data, handshake and status bundle of the IO bridge.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface sys_io_if #(
  parameter int WORD_W = 32,
  parameter int N_CH   = 7,
  parameter int DEPTH  = 8
);
  import sys_io_pkg::*;

  localparam int CNT_W = clog2(DEPTH + 1);

  logic [N_CH*WORD_W-1:0] ps_out_data;
  logic [N_CH-1:0]        ps_out_toggle;
  logic [N_CH-1:0]        ps_out_ack;
  logic [N_CH*WORD_W-1:0] pl_out_data;
  logic [N_CH-1:0]        pl_out_valid;
  logic [N_CH-1:0]        pl_out_ready;
  logic [N_CH-1:0]        pl_out_overrun;
  logic [WORD_W-1:0]      pl_in_data;
  logic                   pl_in_valid;
  logic                   pl_in_ready;
  logic [WORD_W-1:0]      ps_in_data;
  logic [CNT_W-1:0]       ps_in_count;
  logic                   ps_in_pop_toggle;
  logic                   ps_in_irq;
  logic                   ps_in_underrun;

  modport master (
    output ps_out_data, ps_out_toggle, pl_out_ready,
    output pl_in_data, pl_in_valid, ps_in_pop_toggle,
    input  ps_out_ack, pl_out_data, pl_out_valid, pl_out_overrun,
    input  pl_in_ready, ps_in_data, ps_in_count, ps_in_irq, ps_in_underrun
  );

  modport slave (
    input  ps_out_data, ps_out_toggle, pl_out_ready,
    input  pl_in_data, pl_in_valid, ps_in_pop_toggle,
    output ps_out_ack, pl_out_data, pl_out_valid, pl_out_overrun,
    output pl_in_ready, ps_in_data, ps_in_count, ps_in_irq, ps_in_underrun
  );

endinterface

`default_nettype wire

// File: rtl/sys_io_fifo.sv
// ============================================================================
// Module : sys_io_fifo
// Brief  : Register FIFO with pointer-indexed head, zero when empty.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sys_io_fifo
  import sys_io_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WORD_W-1:0]            push_data,
  input  logic                         pop,
  output logic [WORD_W-1:0]            head_data,
  output logic [clog2(DEPTH+1)-1:0]    count,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push;
  logic              w_pop;

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign full      = (r_count == C_DEPTH);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign head_data = empty ? '0 : r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/sys_io_bridge.sv
// ============================================================================
// Module : sys_io_bridge
// Brief  : PS->PL toggle-handshake word channels and PL->PS mailbox FIFO.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sys_io_bridge
  import sys_io_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int N_CH      = 7,
  parameter int DEPTH     = 8,
  parameter int IRQ_LEVEL = 1
) (
  input  logic     sys_clk0,
  input  logic     sys_resetn,
  input  logic     sys_decouple,
  sys_io_if.slave  bus
);

  localparam int CNT_W = clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] C_IRQ_LEVEL = CNT_W'(IRQ_LEVEL);

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    ch_state_t         r_state;
    logic              r_hist;
    logic              r_ack;
    logic              r_ovr;
    logic [WORD_W-1:0] r_data;
    logic              w_edge;
    logic              w_hs;

    assign w_edge = bus.ps_out_toggle[c] != r_hist;
    assign w_hs   = (r_state == CH_PEND) && bus.pl_out_ready[c];

    // While decoupled the channel is frozen; incoming requests are discarded.
    always_ff @(posedge sys_clk0) begin
      if (!sys_resetn) begin
        r_hist  <= bus.ps_out_toggle[c];
        r_state <= CH_IDLE;
        r_ack   <= 1'b0;
        r_ovr   <= 1'b0;
        r_data  <= '0;
      end else begin
        r_hist <= bus.ps_out_toggle[c];
        if (sys_decouple) begin
          if (w_edge) begin
            r_ovr <= 1'b1;
          end
        end else begin
          case (r_state)
            CH_IDLE: begin
              if (w_edge) begin
                r_data  <= bus.ps_out_data[ch_lsb(c, WORD_W) +: WORD_W];
                r_state <= CH_PEND;
              end
            end
            default: begin
              if (w_hs) begin
                r_ack <= ~r_ack;
                if (w_edge) begin
                  r_data <= bus.ps_out_data[ch_lsb(c, WORD_W) +: WORD_W];
                end else begin
                  r_state <= CH_IDLE;
                end
              end else if (w_edge) begin
                r_ovr <= 1'b1;
              end
            end
          endcase
        end
      end
    end

    assign bus.ps_out_ack[c]     = r_ack;
    assign bus.pl_out_overrun[c] = r_ovr;
    assign bus.pl_out_valid[c]   = (r_state == CH_PEND) && !sys_decouple;
    assign bus.pl_out_data[ch_lsb(c, WORD_W) +: WORD_W] = r_data;
  end

  logic              r_pop_hist;
  logic              r_irq;
  logic              r_underrun;
  logic              w_pop_edge;
  logic              w_pop;
  logic              w_push;
  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;

  assign w_pop_edge      = bus.ps_in_pop_toggle != r_pop_hist;
  assign w_pop           = w_pop_edge && !w_empty && !sys_decouple;
  assign bus.pl_in_ready = !w_full && !sys_decouple;
  assign w_push          = bus.pl_in_valid && bus.pl_in_ready;

  sys_io_fifo #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (sys_clk0),
    .rst_n     (sys_resetn),
    .push      (w_push),
    .push_data (bus.pl_in_data),
    .pop       (w_pop),
    .head_data (bus.ps_in_data),
    .count     (w_count),
    .full      (w_full),
    .empty     (w_empty)
  );

  always_ff @(posedge sys_clk0) begin
    if (!sys_resetn) begin
      r_pop_hist <= bus.ps_in_pop_toggle;
      r_irq      <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_pop_hist <= bus.ps_in_pop_toggle;
      r_irq      <= (w_count >= C_IRQ_LEVEL);
      if (w_pop_edge && (w_empty || sys_decouple)) begin
        r_underrun <= 1'b1;
      end
    end
  end

  assign bus.ps_in_count    = w_count;
  assign bus.ps_in_irq      = r_irq;
  assign bus.ps_in_underrun = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_sys_io_bridge.sv
// ============================================================================
// Module : tb_sys_io_bridge
// Brief  : Directed self-checking bench for sys_io_bridge.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_sys_io_bridge;

  localparam int WORD_W = 32;
  localparam int N_CH   = 7;
  localparam int DEPTH  = 8;

  logic sys_clk0;
  logic sys_resetn;
  logic sys_decouple;
  int   n_checks;
  int   n_errors;

  sys_io_if #(.WORD_W(WORD_W), .N_CH(N_CH), .DEPTH(DEPTH)) bus ();

  sys_io_bridge #(
    .WORD_W    (WORD_W),
    .N_CH      (N_CH),
    .DEPTH     (DEPTH),
    .IRQ_LEVEL (1)
  ) dut (
    .sys_clk0     (sys_clk0),
    .sys_resetn   (sys_resetn),
    .sys_decouple (sys_decouple),
    .bus          (bus)
  );

  initial sys_clk0 = 1'b0;
  always #5 sys_clk0 = ~sys_clk0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk0);
    #1;
  endtask

  task automatic ch_send(input int c, input logic [WORD_W-1:0] w);
    bus.ps_out_data[c*WORD_W +: WORD_W] = w;
    bus.ps_out_toggle[c] = ~bus.ps_out_toggle[c];
  endtask

  function automatic logic [WORD_W-1:0] ch_word(input int c);
    return bus.pl_out_data[c*WORD_W +: WORD_W];
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    sys_resetn           = 1'b0;
    sys_decouple         = 1'b0;
    bus.ps_out_data      = '0;
    bus.ps_out_toggle    = 7'h55;
    bus.pl_out_ready     = '0;
    bus.pl_in_data       = '0;
    bus.pl_in_valid      = 1'b0;
    bus.ps_in_pop_toggle = 1'b1;

    // 1: reset with toggles held high
    repeat (3) tick();
    sys_resetn = 1'b1;
    repeat (2) tick();
    chk("rst_valid",    64'(bus.pl_out_valid),   64'h0);
    chk("rst_overrun",  64'(bus.pl_out_overrun), 64'h0);
    chk("rst_ack",      64'(bus.ps_out_ack),     64'h0);
    chk("rst_data_ch6", 64'(ch_word(6)),         64'h0);
    chk("rst_count",    64'(bus.ps_in_count),    64'h0);
    chk("rst_irq",      64'(bus.ps_in_irq),      64'h0);
    chk("rst_underrun", 64'(bus.ps_in_underrun), 64'h0);
    chk("rst_in_data",  64'(bus.ps_in_data),     64'h0);
    chk("rst_in_ready", 64'(bus.pl_in_ready),    64'h1);

    // 2: channel 2 single transfer
    ch_send(2, 32'hDEAD_BEEF);
    tick();
    chk("ch2_valid", 64'(bus.pl_out_valid), 64'h04);
    chk("ch2_data",  64'(ch_word(2)),       64'hDEAD_BEEF);
    bus.pl_out_ready[2] = 1'b1;
    tick();
    bus.pl_out_ready[2] = 1'b0;
    chk("ch2_valid_drop", 64'(bus.pl_out_valid), 64'h0);
    chk("ch2_ack",        64'(bus.ps_out_ack),   64'h04);

    // 3a: ch0 overrun while pending
    ch_send(0, 32'hA5A5_0001);
    tick();
    chk("ch0_valid", 64'(bus.pl_out_valid[0]), 64'h1);
    ch_send(0, 32'h0000_0001);
    tick();
    chk("ch0_overrun", 64'(bus.pl_out_overrun), 64'h01);
    chk("ch0_held",    64'(ch_word(0)),         64'hA5A5_0001);
    chk("ch0_still_v", 64'(bus.pl_out_valid[0]), 64'h1);
    bus.pl_out_ready[0] = 1'b1;
    tick();
    bus.pl_out_ready[0] = 1'b0;
    chk("ch0_ack", 64'(bus.ps_out_ack[0]), 64'h1);

    // 3b: ch3 back-to-back request with handshake in the same cycle
    ch_send(3, 32'h1234_5678);
    tick();
    ch_send(3, 32'h8765_4321);
    bus.pl_out_ready[3] = 1'b1;
    tick();
    bus.pl_out_ready[3] = 1'b0;
    chk("ch3_valid",   64'(bus.pl_out_valid[3]),   64'h1);
    chk("ch3_data",    64'(ch_word(3)),            64'h8765_4321);
    chk("ch3_ack",     64'(bus.ps_out_ack[3]),     64'h1);
    chk("ch3_overrun", 64'(bus.pl_out_overrun[3]), 64'h0);
    bus.pl_out_ready[3] = 1'b1;
    tick();
    bus.pl_out_ready[3] = 1'b0;
    chk("ch3_ack2", 64'(bus.ps_out_ack[3]), 64'h0);

    // 4: fill FIFO, drain, then underrun
    bus.pl_in_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      bus.pl_in_data = 32'(i);
      tick();
      if (i == 0) chk("irq_lag0", 64'(bus.ps_in_irq), 64'h0);
      if (i == 1) chk("irq_lag1", 64'(bus.ps_in_irq), 64'h1);
    end
    bus.pl_in_valid = 1'b0;
    chk("full_count", 64'(bus.ps_in_count), 64'd8);
    chk("full_ready", 64'(bus.pl_in_ready), 64'h0);
    chk("full_irq",   64'(bus.ps_in_irq),   64'h1);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_head", 64'(bus.ps_in_data), 64'(i));
      bus.ps_in_pop_toggle = ~bus.ps_in_pop_toggle;
      tick();
    end
    chk("drain_zero",  64'(bus.ps_in_data),  64'h0);
    chk("drain_count", 64'(bus.ps_in_count), 64'h0);
    tick();
    chk("drain_irq", 64'(bus.ps_in_irq), 64'h0);
    chk("pre_underrun", 64'(bus.ps_in_underrun), 64'h0);
    bus.ps_in_pop_toggle = ~bus.ps_in_pop_toggle;
    tick();
    chk("underrun",       64'(bus.ps_in_underrun), 64'h1);
    chk("underrun_count", 64'(bus.ps_in_count),    64'h0);

    // 5: simultaneous push/pop at count 3
    bus.pl_in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.pl_in_data = 32'(100 + i);
      tick();
    end
    bus.pl_in_data = 32'd103;
    bus.ps_in_pop_toggle = ~bus.ps_in_pop_toggle;
    tick();
    bus.pl_in_valid = 1'b0;
    chk("pp_count", 64'(bus.ps_in_count), 64'd3);
    for (int i = 1; i < 4; i++) begin
      chk("pp_order", 64'(bus.ps_in_data), 64'(100 + i));
      bus.ps_in_pop_toggle = ~bus.ps_in_pop_toggle;
      tick();
    end
    chk("pp_empty", 64'(bus.ps_in_count), 64'd0);

    // 5b: 20 push/pop pairs across pointer wrap
    bus.pl_in_valid = 1'b1;
    bus.pl_in_data  = 32'd500;
    tick();
    for (int i = 0; i < 20; i++) begin
      chk("wrap_head", 64'(bus.ps_in_data), 64'(500 + i));
      bus.pl_in_data = 32'(501 + i);
      bus.ps_in_pop_toggle = ~bus.ps_in_pop_toggle;
      tick();
      chk("wrap_count", 64'(bus.ps_in_count), 64'd1);
    end
    bus.pl_in_valid = 1'b0;
    chk("wrap_last", 64'(bus.ps_in_data), 64'd520);
    bus.ps_in_pop_toggle = ~bus.ps_in_pop_toggle;
    tick();
    chk("wrap_empty", 64'(bus.ps_in_count), 64'd0);

    // 6: decouple with ch1 pending
    ch_send(1, 32'h1111_2222);
    tick();
    chk("dc_pre_valid", 64'(bus.pl_out_valid[1]), 64'h1);
    sys_decouple = 1'b1;
    bus.pl_out_ready[1] = 1'b1;
    ch_send(1, 32'h3333_4444);
    tick();
    chk("dc_masked",   64'(bus.pl_out_valid),      64'h0);
    chk("dc_overrun",  64'(bus.pl_out_overrun[1]), 64'h1);
    chk("dc_in_ready", 64'(bus.pl_in_ready),       64'h0);
    chk("dc_no_ack",   64'(bus.ps_out_ack[1]),     64'h0);
    bus.pl_out_ready[1] = 1'b0;
    sys_decouple = 1'b0;
    tick();
    chk("dc_revalid", 64'(bus.pl_out_valid[1]), 64'h1);
    chk("dc_word",    64'(ch_word(1)),          64'h1111_2222);
    bus.pl_out_ready[1] = 1'b1;
    tick();
    bus.pl_out_ready[1] = 1'b0;
    chk("dc_ack",   64'(bus.ps_out_ack[1]),   64'h1);
    chk("dc_done",  64'(bus.pl_out_valid[1]), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sys_io_bridge.md
# sys_io_bridge

Parametrised PS↔PL mailbox between the Zynq system block's serial GPIO buses and user logic.
- PS→PL: N_CH independent word channels, each with a toggle-request / toggle-acknowledge handshake on the PS side and valid/ready on the PL side.
- PL→PS: a DEPTH-entry FIFO whose head word is presented to the PS, with a level interrupt and toggle-driven pop.
- Generalises the fixed-width flat buses: word width, channel count, FIFO depth and interrupt threshold are parameters, and the block honours partial-reconfiguration decoupling.

## Interface
- WORD_W, 32: word width, PS→PL and PL→PS.
- N_CH, 7: number of PS→PL channels, 1..16.
- DEPTH, 8: PL→PS FIFO depth, power of two, ≥2.
- IRQ_LEVEL, 1: FIFO occupancy at or above which ps_in_irq asserts, 1..DEPTH.

Ports:
- sys_clk0  in  1  sole clock; all logic is on its rising edge.
- sys_resetn  in  1  synchronous, active-low reset.
- sys_decouple  in  1  PR decouple; freezes the PL side while high.
- ps_out_data  in  N_CH*WORD_W  PS words; channel c occupies bits [c*WORD_W +: WORD_W].
- ps_out_toggle  in  N_CH  PS request; any level change = new word on channel c.
- ps_out_ack  out  N_CH  toggles once per word consumed by the PL.
- pl_out_data  out  N_CH*WORD_W  captured words, held stable while valid.
- pl_out_valid  out  N_CH  per-channel valid.
- pl_out_ready  in  N_CH  per-channel ready.
- pl_out_overrun  out  N_CH  sticky: a request was dropped.
- pl_in_data  in  WORD_W  PL→PS word.
- pl_in_valid  in  1  push request.
- pl_in_ready  out  1  asserted when `!full && !sys_decouple`.
- ps_in_data  out  WORD_W  FIFO head; 0 when empty.
- ps_in_count  out  $clog2(DEPTH+1)  FIFO occupancy.
- ps_in_pop_toggle  in  1  PS pop request; any level change = pop one.
- ps_in_irq  out  1  registered, equals `count >= IRQ_LEVEL`.
- ps_in_underrun  out  1  sticky: pop requested while empty.

## Operation
- **Reset** (sys_resetn low at a clock edge):
  - All outputs go to 0: data, valid, ack, overrun, count, irq, underrun.
  - Toggle-history registers load the current ps_out_toggle and ps_in_pop_toggle, so a reset mid-operation generates no spurious edge.
  - FIFO pointers clear.
- **PS→PL channel c**, two states, IDLE and PEND:
  - Edge = ps_out_toggle[c] ≠ hist[c]; hist[c] updates every cycle.
  - IDLE + edge: capture the word, go to PEND.
  - PEND + valid&ready: toggle ps_out_ack[c], go to IDLE.
  - PEND + edge, no handshake in the same cycle: the new word is dropped, overrun[c] is set, the held word is kept.
  - PEND + edge and handshake in the same cycle: ack toggles, the new word is captured, the channel stays PEND, no overrun.
- **FIFO**:
  - A push occurs when pl_in_valid && pl_in_ready.
  - A pop occurs on a pop edge when the FIFO is not empty; a pop edge on empty is ignored and sets underrun.
  - Simultaneous push and pop: count is unchanged and both take effect. Since pl_in_ready is low when full, a push at full is impossible.
  - Pointers wrap modulo DEPTH; count saturates by construction in 0..DEPTH.
- **Decouple high**:
  - pl_out_valid is masked to 0 and pl_in_ready is forced to 0.
  - Channel state and FIFO contents are frozen.
  - Histories still update, so toggles arriving during decouple are discarded. Each discarded request sets overrun (channels) or underrun (pop).
  - When decouple drops, pending words re-present with no loss.

## Timing
- Request edge at clock T: pl_out_valid is high and pl_out_data is valid from T+1.
- Handshake at T: valid is low and the ack toggle is visible at T+1; a new request can be captured at T+1.
- Push at T: ps_in_count increments at T+1. If the FIFO was empty, ps_in_data shows the word from T+1.
- ps_in_irq follows count one cycle later, i.e. T+2 after the push.
- Pop edge at T: ps_in_data shows the next head (or 0) at T+1.
- Maximum throughput: one word per cycle per channel and per FIFO direction.
- No combinational path from any input to any output, with two exceptions:
  - pl_in_ready, from full and sys_decouple;
  - pl_out_valid masking, from sys_decouple.

## Structure
- Shared package/header `sys_io_pkg`:
  - clog2 helper;
  - channel slice macro/function (c*WORD_W +: WORD_W);
  - channel state encoding IDLE=0, PEND=1.
- Sub-module `sys_io_fifo` (parameters WORD_W, DEPTH; ports push/pop/data/count/full/empty): synchronous-reset register FIFO. The head is registered-pointer-indexed and muxed to 0 when empty.
- Per-channel logic in a generate loop inside `sys_io_bridge`.

## Test plan
1. Reset with ps_out_toggle=7'h55 held → no valid and no overrun after release; all outputs 0.
2. Ch2: data 32'hDEAD_BEEF, toggle → valid[2] at T+1 with that data; ready pulse → ack[2] toggles, valid drops at T+1.
3. Ch0 pending, second toggle with data 32'h1, ready low → overrun[0]=1, data still the first word. Repeat with ready high in the same cycle → new word captured, no overrun.
4. Push 8 words 0..7 with DEPTH=8 → pl_in_ready=0, count=8, irq=1. Pop 8 toggles → ps_in_data sequence 0..7 then 0, count=0. Ninth pop → underrun=1.
5. Simultaneous push and pop at count=3 → count stays 3 and FIFO order is preserved. Wrap test: 20 push/pop pairs, data matches.
6. Decouple high with ch1 pending: toggle ch1 → valid masked, overrun[1]=1. Deassert decouple → the original ch1 word is presented.
